// File: rtl/letter_seq.sv
// letter_seq: steps a one-hot letter select through "dEAF" (or its reverse).
// Advances come from a prescaler tick in auto mode or a synchronized step press in manual mode.
module letter_seq #(
  parameter int DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       mode,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] y,
  output logic       word_done,
  output logic [3:0] word_cnt
);
  localparam int PW = $clog2(DIV);
  typedef enum logic [3:0] {
    BLANK = 4'b0000,
    D     = 4'b1000,
    E     = 4'b0010,
    A     = 4'b0100,
    F     = 4'b0001
  } state_t;
  state_t        state, state_nx;
  logic [PW-1:0] cnt;
  logic [2:0]    sync;
  logic          tick, pulse, adv, done_nx;
  assign tick    = en && !mode && cnt == PW'(DIV - 1);
  assign pulse   = sync[1] && !sync[2];
  assign adv     = en && (mode ? pulse : tick);
  assign done_nx = adv && state != BLANK && state_nx == BLANK;
  // state encoding is the one-hot letter select itself, so y is a pure register copy
  assign y       = state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (!en || mode || tick) cnt <= '0;
    else cnt <= cnt + PW'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[1:0], step};
  always_comb begin
    state_nx = state;
    if (adv)
      case (state)
        BLANK:   state_nx = dir ? F : D;
        D:       state_nx = dir ? BLANK : E;
        E:       state_nx = dir ? D : A;
        A:       state_nx = dir ? E : F;
        F:       state_nx = dir ? A : BLANK;
        default: state_nx = BLANK;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= BLANK;
      word_done <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nx;
      word_done <= done_nx;
      word_cnt  <= done_nx ? word_cnt + 4'd1 : word_cnt;
    end
endmodule

// File: tb/tb_letter_seq.sv
// tb_letter_seq: directed checks of letter_seq with DIV=4.
module tb_letter_seq;
  logic       clk = 1'b0;
  logic       reset_n, en, mode, dir, step;
  logic [3:0] y, word_cnt;
  logic       word_done;
  int         tests = 0, fails = 0, n_done;
  logic [3:0] fwd_seq [0:5] = '{4'h0, 4'h8, 4'h2, 4'h4, 4'h1, 4'h0};

  letter_seq #(.DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .dir(dir), .step(step),
    .y(y), .word_done(word_done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] prev, input logic [3:0] exp, input int hold);
    step = 1'b1;
    cyc(1); check("press_e1", y, prev);
    cyc(1); check("press_e2", y, prev);
    cyc(1); check("press_e3", y, exp);
    cyc(hold - 3); check("press_hold", y, exp);
    step = 1'b0;
    cyc(4); check("press_idle", y, exp);
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; step = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_y", y, 4'h0);
    check("rst_wd", word_done, 1'b0);
    check("rst_cnt", word_cnt, 4'h0);
    @(negedge clk);
    reset_n = 1'b1; en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      check("auto_y", y, fwd_seq[c/4]);
      check("auto_wd", word_done, c == 20);
    end
    check("auto_cnt", word_cnt, 4'd1);

    mode = 1'b1; dir = 1'b1;
    press(4'h0, 4'h1, 5);
    press(4'h1, 4'h4, 5);
    press(4'h4, 4'h2, 5);
    press(4'h2, 4'h8, 50);

    mode = 1'b0; dir = 1'b0;
    cyc(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1); check("freeze_y", y, 4'h8);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1); check("unfreeze_wait", y, 4'h8);
    end
    cyc(1); check("unfreeze_adv", y, 4'h2);

    dir = 1'b1;
    cyc(3); check("flip_wait", y, 4'h2);
    cyc(1); check("flip_d", y, 4'h8);
    check("flip_d_wd", word_done, 1'b0);
    cyc(3); check("flip_wait2", y, 4'h8);
    cyc(1); check("flip_blank", y, 4'h0);
    check("flip_wd", word_done, 1'b1);
    check("flip_cnt", word_cnt, 4'd2);
    cyc(1); check("flip_wd_drop", word_done, 1'b0);

    #2 reset_n = 1'b0;
    #1 check("rst2_cnt", word_cnt, 4'h0);
    @(negedge clk);
    reset_n = 1'b1; dir = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 320; c++) begin
      cyc(1);
      if (word_done) n_done++;
      if (c == 300) check("wrap_cnt15", word_cnt, 4'd15);
    end
    check("wrap_pulses", n_done, 16);
    check("wrap_cnt", word_cnt, 4'd0);
    check("wrap_y", y, 4'h0);

    cyc(12); check("pre_rst_y", y, 4'h4);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_y", y, 4'h0);
    check("async_rst_cnt", word_cnt, 4'h0);
    check("async_rst_wd", word_done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(3); check("post_rst_wait", y, 4'h0);
    cyc(1); check("post_rst_adv", y, 4'h8);

    mode = 1'b1; step = 1'b1;
    #2 reset_n = 1'b0;
    #1 check("step_rst_y", y, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1); check("step_rel_e1", y, 4'h0);
    cyc(1); check("step_rel_e2", y, 4'h0);
    cyc(1); check("step_rel_e3", y, 4'h8);
    cyc(5); check("step_rel_hold", y, 4'h8);

    step = 1'b0;
    cyc(3);
    en = 1'b0; step = 1'b1;
    cyc(5);
    step = 1'b0;
    cyc(3); check("en0_step", y, 4'h8);
    en = 1'b1;
    cyc(4); check("en0_no_late", y, 4'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
